exo1_sdiv_32s_32s_32_seq: RTL
=============================

// Module: exo1_sdiv_32s_32s_32_seq
// PURPOSE
//  Iterative signed 32/32 divider; the inverse operator to the team's pipelined signed multiplier.
//  Computes quotient and remainder with C semantics: truncate toward zero, remainder takes the dividend's sign.
//  Radix-2 restoring algorithm, one quotient bit per enabled cycle, start/done handshake.
//  Honours the same ce stall convention as the datapath operators.
//  Sits in the exo1 datapath beside the multiplier.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  din0_WIDTH  32  dividend width (signed)
//  din1_WIDTH  32  divisor width (signed)
//  dout_WIDTH  32  quotient/remainder width; must equal din0_WIDTH
// PORTS
//  clk       in   1           rising-edge clock
//  reset     in   1           asynchronous, active-low reset (0 = reset)
//  ce        in   1           clock enable; when 0, all state and outputs hold
//  start     in   1           request; sampled only when ce=1 and ready=1
//  din0      in   din0_WIDTH  dividend, captured with start
//  din1      in   din1_WIDTH  divisor, captured with start
//  ready     out  1           1 in IDLE: block can accept start
//  done      out  1           single-cycle pulse: quot/rem/flags valid
//  quot      out  dout_WIDTH  signed quotient, held until the next done
//  rem       out  dout_WIDTH  signed remainder, held until the next done
//  div_zero  out  1           divisor was 0 for the result now presented
//  ovf       out  1           operands were INT_MIN / -1 for the result now presented
// BEHAVIOUR
//  Reset (async assert, sync release) drives the FSM to IDLE and all outputs to 0, except ready=1.
//  All register updates require ce=1. With ce=0 every flop holds, including the one-cycle done pulse.
//  FSM states:
//   IDLE  ready=1. start=1 captures |din0|, |din1|, sign_q=din0[msb]^din1[msb] and sign_r=din0[msb].
//         Clears the remainder accumulator, loads counter=dout_WIDTH-1, goes to CALC.
//   CALC  Each enabled cycle shifts {acc,dvd} left by 1 and computes trial=acc-dvs (width dout_WIDTH+1).
//         If trial>=0, acc=trial and quotient bit=1; otherwise the quotient bit=0.
//         At counter==0 goes to FIX; otherwise decrements the counter.
//   FIX   Applies signs: quot=sign_q?-q:q, rem=sign_r?-r:r. Registers the outputs and flags.
//         Asserts done for one enabled cycle and returns to IDLE.
//  Latency: done=1 on exactly dout_WIDTH+2 enabled edges after the edge that sampled start.
//   ce=0 cycles add latency one-for-one.
//  Throughput: one operation per dout_WIDTH+2 cycles. ready=0 from the start edge until FIX exits.
//   start while ready=0 is ignored.
//  start on the same edge that FIX returns to IDLE is not accepted. ready is 0 during FIX.
//  Magnitudes use dout_WIDTH-bit unsigned arithmetic, so |INT_MIN|=2^31 is represented correctly.
//  Divisor 0: latency is unchanged. Outputs are quot=all-ones (-1), rem=din0 and div_zero=1.
//  INT_MIN / -1: outputs are quot=INT_MIN (two's-complement wrap), rem=0 and ovf=1.
//  div_zero and ovf are registered with quot/rem and hold with them.
//  Reset mid-operation aborts the operation: no done, outputs return to 0, ready=1.
//  Operand inputs are don't-care outside the start-sampling cycle.
// STRUCTURE
//  Shared package exo1_pkg:
//   - state enum {IDLE, CALC, FIX}
//   - localparam for the counter width, $clog2(dout_WIDTH)
//   - INT_MIN constant function of the width
//  One sub-module: exo1_sdiv_core_step. This is the combinational shift/trial-subtract slice,
//   one quotient bit per instance, reusable for an unrolled variant.
//  FSM, counter, sign logic and output registers stay in the top.
// TESTING
//  1. 100/7 with ce=1 held -> done exactly 34 cycles after start; quot=14, rem=2, flags 0.
//  2. -100/7 -> quot=-14, rem=-2. 100/-7 -> quot=-14, rem=2. -100/-7 -> quot=14, rem=-2.
//  3. 0x80000000/-1 -> quot=0x80000000, rem=0, ovf=1. 0x80000000/1 -> quot=0x80000000, rem=0, ovf=0.
//  4. 55/0 -> quot=0xFFFFFFFF, rem=55, div_zero=1, latency still 34.
//  5. 1000/3 with ce low for 5 random cycles mid-CALC -> done at 39 cycles, quot=333, rem=1.
//      During ce=0, done and outputs are frozen.
//  6. reset=0 at CALC cycle 10, then release and start 9/4:
//      no stale done; ready=1 after reset; quot=2, rem=1.
//      A start asserted while ready=0 is ignored.
//  Random: 10k operand pairs vs a reference model ($signed / and %), including 0, ±1, INT_MIN and INT_MAX.

Source files
------------

// File: rtl/exo1_pkg.sv
// Shared types and constants for the exo1 datapath operators.
package exo1_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  localparam int unsigned DoutWidth = 32;
  localparam int unsigned CntWidth  = $clog2(DoutWidth);

  // Most negative two's-complement value of the given width, right-aligned in 64 bits.
  function automatic logic [63:0] int_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/exo1_sdiv_core_step.sv
// One radix-2 restoring-division slice: shift {acc,dvd} left, trial-subtract the divisor.
module exo1_sdiv_core_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] acc_i,
  input  logic [Width-1:0] dvd_i,
  input  logic [Width-1:0] dvs_i,
  output logic [Width-1:0] acc_o,
  output logic [Width-1:0] dvd_o
);

  logic [Width:0] shifted;
  logic [Width:0] trial;
  logic           neg;

  // acc < dvs holds on entry, so shifted never exceeds Width bits and trial fits Width+1 signed.
  always_comb begin
    shifted = {acc_i, dvd_i[Width-1]};
    trial   = shifted - {1'b0, dvs_i};
    neg     = trial[Width];
    acc_o   = neg ? shifted[Width-1:0] : trial[Width-1:0];
    dvd_o   = {dvd_i[Width-2:0], ~neg};
  end

endmodule

// File: rtl/exo1_sdiv_32s_32s_32_seq.sv
// Iterative signed divider, C semantics (truncate toward zero), start/done handshake with ce stall.
module exo1_sdiv_32s_32s_32_seq
  import exo1_pkg::*;
#(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 32,
  parameter int unsigned din1_WIDTH = 32,
  parameter int unsigned dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  div_zero,
  output logic                  ovf
);

  localparam int unsigned W    = dout_WIDTH;
  localparam int unsigned CntW = $clog2(W);
  localparam logic [63:0] IntMinWide = int_min(W);
  localparam logic [W-1:0] IntMin    = IntMinWide[W-1:0];

  if (dout_WIDTH != din0_WIDTH) begin : g_bad_width
    $error("exo1_sdiv ID %0d: dout_WIDTH must equal din0_WIDTH", ID);
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      dvd_q, dvd_d;
  logic [W-1:0]      dvs_q, dvs_d;
  logic              sign_q_q, sign_q_d;
  logic              sign_r_q, sign_r_d;
  logic              dz_q, dz_d;
  logic              ov_q, ov_d;
  logic              pend_q, pend_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [W-1:0]      quot_q, quot_d;
  logic [W-1:0]      rem_q, rem_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;

  logic [W-1:0] a_ext, b_ext, abs_a, abs_b;
  logic         a_neg, b_neg;
  logic [W-1:0] step_acc, step_dvd;

  // Magnitudes are W-bit unsigned, so |INT_MIN| is exact.
  always_comb begin
    a_ext = W'(din0);
    b_ext = W'($signed(din1));
    a_neg = a_ext[W-1];
    b_neg = b_ext[W-1];
    abs_a = a_neg ? -a_ext : a_ext;
    abs_b = b_neg ? -b_ext : b_ext;
  end

  exo1_sdiv_core_step #(
    .Width(W)
  ) u_step (
    .acc_i(acc_q),
    .dvd_i(dvd_q),
    .dvs_i(dvs_q),
    .acc_o(step_acc),
    .dvd_o(step_dvd)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    dz_d       = dz_q;
    ov_d       = ov_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    pend_d     = (state_q == StFix);
    done_d     = pend_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCalc;
          acc_d    = '0;
          dvd_d    = abs_a;
          dvs_d    = abs_b;
          sign_q_d = a_neg ^ b_neg;
          sign_r_d = a_neg;
          dz_d     = (b_ext == '0);
          ov_d     = (a_ext == IntMin) && (b_ext == '1);
          cnt_d    = CntW'(W - 1);
        end
      end
      StCalc: begin
        acc_d = step_acc;
        dvd_d = step_dvd;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        // Signs applied in place; the result registers load on the following edge with done.
        dvd_d   = sign_q_q ? -dvd_q : dvd_q;
        acc_d   = sign_r_q ? -acc_q : acc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reads pre-edge working values, so a start sampled on this same edge cannot corrupt them.
    if (pend_q) begin
      quot_d     = dz_q ? '1 : dvd_q;
      rem_d      = acc_q;
      div_zero_d = dz_q;
      ovf_d      = ov_q;
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      dz_q       <= dz_d;
      ov_q       <= ov_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;

endmodule
